product_accumulator: RTL
========================

// Module: product_accumulator
// PURPOSE
//  Downstream stage of the array multiplier. Consumes the unsigned product word z
//  through a valid/ready handshake and sums N consecutive products (dot product).
//  Presents the registered sum with its own valid/ready handshake and holds it
//  until the consumer accepts it. Single clock domain.
// PARAMETERS
//  PW     4  width of incoming product (array multiplier z width)
//  N      4  products per result; legal range 2..255
//  ACC_W  6  accumulator/result width; PW+clog2(N) guarantees no overflow
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous reset, active-high
//  clear      in   1      abort partial accumulation (ACCUM state only)
//  in_valid   in   1      in_prod valid
//  in_ready   out  1      stage can accept in_prod
//  in_prod    in   PW     unsigned product from multiplier
//  out_valid  out  1      out_sum/out_ovf valid
//  out_ready  in   1      consumer accepts result
//  out_sum    out  ACC_W  sum of N products, modulo 2^ACC_W
//  out_ovf    out  1      sticky: some add in this result carried out of ACC_W
// BEHAVIOUR
//  - Reset (rst=1 at posedge, any state): state=ACCUM, acc=0, cnt=0, ovf_acc=0,
//    out_valid=0, out_sum=0, out_ovf=0. Reset mid-accumulation or mid-HOLD drops
//    all partial/pending data; no result is emitted for it.
//  - in_ready = (state==ACCUM) && !clear  (combinational). Accept = in_valid&&in_ready.
//  - in_prod zero-extended to ACC_W+1 before add; bit ACC_W of each add ORs into ovf.
//  - FSM, two states:
//    ACCUM: on accept with cnt<N-1: acc<=acc+prod, cnt<=cnt+1, ovf_acc updated.
//           on accept with cnt==N-1: out_sum<=acc+prod (low ACC_W bits),
//           out_ovf<=ovf_acc|carry, out_valid<=1, acc<=0, cnt<=0, ovf_acc<=0,
//           state<=HOLD. Latency: out_valid high the cycle after Nth accept.
//           clear=1: acc<=0, cnt<=0, ovf_acc<=0; concurrent in_valid not accepted.
//           no accept, no clear: all state held.
//    HOLD:  out_valid=1, out_sum/out_ovf stable; in_ready=0; clear ignored.
//           out_ready=1: out_valid<=0, state<=ACCUM (new input accepted from the
//           following cycle; one bubble per result is permitted).
//  - out_sum/out_ovf keep last value after handoff until next result loads.
//  - Arithmetic unsigned, wrap-around modulo 2^ACC_W; out_ovf flags the wrap.
//  - No combinational path from in_valid/in_prod to out_*; out_ready does not
//    affect in_ready in the same cycle.
// TESTING (N=4, PW=4 unless stated)
//  1 ACC_W=6, accept 9,9,9,9 back-to-back -> next cycle out_valid=1, out_sum=36,
//    out_ovf=0; out_ready=1 -> out_valid=0 following cycle, in_ready=1.
//  2 ACC_W=5, accept 9,9,9,9 -> out_sum=4, out_ovf=1; next result 1,1,1,1 ->
//    out_sum=4, out_ovf=0 (sticky cleared per result).
//  3 Backpressure: complete 1,2,3,4, hold out_ready=0 for 5 cycles -> out_sum=10
//    stable, out_valid=1, in_ready=0 throughout; in_valid pulses ignored.
//  4 Accept 15,15, then clear=1 with in_valid=1 (in_ready=0, not accepted),
//    then 1,2,3,4 -> out_sum=10.
//  5 Gaps: in_valid toggled 1/0 each cycle over 3,0,5,7 -> out_sum=15 one cycle
//    after 4th accept; zero products counted toward N.
//  6 Assert rst after 2 accepts and again during HOLD -> all outputs 0 next
//    cycle, in_ready=1; then 2,2,2,2 -> out_sum=8.

Source files
------------

// File: rtl/product_accumulator.sv
// product_accumulator: sums N consecutive unsigned products behind valid/ready handshakes
// and holds each registered result, with a sticky carry-out flag, until it is consumed.
module product_accumulator #(
    parameter int PW    = 4,
    parameter int N     = 4,
    parameter int ACC_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PW-1:0]    in_prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);
    localparam int CW = $clog2(N);
    typedef enum logic {ACCUM, HOLD} state_t;
    state_t state, state_n;
    logic [ACC_W-1:0] acc, acc_n, out_sum_n;
    logic [CW-1:0] cnt, cnt_n;
    logic ovf_acc, ovf_acc_n, out_valid_n, out_ovf_n;
    logic [ACC_W:0] sum;
    // the extra top bit of the sum is the carry-out of this add
    assign sum = {1'b0, acc} + {{(ACC_W + 1 - PW){1'b0}}, in_prod};
    assign in_ready = (state == ACCUM) && !clear;
    always_comb begin
        state_n = state;
        acc_n = acc;
        cnt_n = cnt;
        ovf_acc_n = ovf_acc;
        out_valid_n = out_valid;
        out_sum_n = out_sum;
        out_ovf_n = out_ovf;
        if (state == ACCUM) begin
            if (clear) begin
                acc_n = '0;
                cnt_n = '0;
                ovf_acc_n = 1'b0;
            end else if (in_valid) begin
                if (cnt == CW'(N - 1)) begin
                    out_sum_n = sum[ACC_W-1:0];
                    out_ovf_n = ovf_acc | sum[ACC_W];
                    out_valid_n = 1'b1;
                    acc_n = '0;
                    cnt_n = '0;
                    ovf_acc_n = 1'b0;
                    state_n = HOLD;
                end else begin
                    acc_n = sum[ACC_W-1:0];
                    cnt_n = cnt + 1'b1;
                    ovf_acc_n = ovf_acc | sum[ACC_W];
                end
            end
        end else if (out_ready) begin
            out_valid_n = 1'b0;
            state_n = ACCUM;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
            acc <= '0;
            cnt <= '0;
            ovf_acc <= 1'b0;
            out_valid <= 1'b0;
            out_sum <= '0;
            out_ovf <= 1'b0;
        end else begin
            state <= state_n;
            acc <= acc_n;
            cnt <= cnt_n;
            ovf_acc <= ovf_acc_n;
            out_valid <= out_valid_n;
            out_sum <= out_sum_n;
            out_ovf <= out_ovf_n;
        end
    end
endmodule
